// File: rtl/dmem_port_arbiter_if.sv
// ============================================================================
// Module : dmem_port_arbiter_if
// Brief  : Bundles the core, external and DataMemory sides of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // core load/store path
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    // external debug/DMA requester
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic          ext_gnt;
    logic          ext_rvalid;
    logic [DW-1:0] ext_rdata;

    // DataMemory port
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    // Requesters and memory together form the master view.
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_stall, core_rvalid, core_rdata,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_rvalid, ext_rdata,
        input  mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data
    );

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_stall, core_rvalid, core_rdata,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_rvalid, ext_rdata,
        output mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data
    );
endinterface

`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Per-cycle arbiter sharing the DataMemory port between the core and
//          an external requester; core priority with bounded ext starvation.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    dmem_port_arbiter_if.slave bus
);

    localparam int            CW         = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] c_max_wait = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } rd_owner_e;

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    rd_owner_e     rd_owner_q;
    rd_owner_e     rd_owner_d;

    logic ext_gnt;
    logic core_gnt;

    // Grants are qualified by reset so nothing reaches memory while it is low.
    always_comb begin
        ext_gnt  = reset && bus.ext_req &&
                   (!bus.core_req || (wait_cnt_q >= c_max_wait));
        core_gnt = reset && bus.core_req && !ext_gnt;
    end

    always_comb begin
        bus.ext_gnt    = ext_gnt;
        bus.core_stall = bus.core_req && ext_gnt;

        bus.mem_wr_en   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_data = '0;
        if (ext_gnt) begin
            bus.mem_wr_en   = bus.ext_we;
            bus.mem_addr    = bus.ext_addr;
            bus.mem_wr_data = bus.ext_wdata;
        end else if (core_gnt) begin
            bus.mem_wr_en   = bus.core_we;
            bus.mem_addr    = bus.core_addr;
            bus.mem_wr_data = bus.core_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (bus.ext_req && !ext_gnt) begin
            wait_cnt_d = (wait_cnt_q >= c_max_wait) ? c_max_wait
                                                    : wait_cnt_q + CW'(1);
        end
    end

    always_comb begin
        rd_owner_d = OWN_NONE;
        if (ext_gnt && !bus.ext_we) begin
            rd_owner_d = OWN_EXT;
        end else if (core_gnt && !bus.core_we) begin
            rd_owner_d = OWN_CORE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            rd_owner_q <= OWN_NONE;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // The owner recorded at grant time steers the returning memory data.
    always_comb begin
        bus.core_rvalid = (rd_owner_q == OWN_CORE);
        bus.ext_rvalid  = (rd_owner_q == OWN_EXT);
        bus.core_rdata  = bus.core_rvalid ? bus.mem_rd_data : '0;
        bus.ext_rdata   = bus.ext_rvalid  ? bus.mem_rd_data : '0;
    end

endmodule

`default_nettype wire

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters:
  - the core load/store path (ALU address, store data, memWrEn);
  - an external debug/DMA requester (replaces the raw exadd/exdata read tap and adds writes).
- Arbitration is per cycle. The core has priority, with a bounded-starvation guarantee for the external side.
- Read data returns one cycle after grant and is routed back to the requester that issued the read.
- Sits between the datapath and DataMemory. core_stall drives the PC/register-file hold logic.

Parameters:
- AW, 32, address width (byte address, passed through unmodified).
- DW, 32, data width.
- MAX_WAIT, 4, maximum consecutive cycles ext_req may be denied before a forced external grant (≥1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core requests a memory access this cycle.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  AW  core access address.
- core_wdata  in  DW  core store data.
- core_stall  out  1  core access not granted this cycle; core holds state and request.
- core_rvalid  out  1  core load data valid this cycle.
- core_rdata  out  DW  core load data.
- ext_req  in  1  external request; held with fields stable until ext_gnt.
- ext_we  in  1  1 = write, 0 = read.
- ext_addr  in  AW  external address.
- ext_wdata  in  DW  external write data.
- ext_gnt  out  1  external access accepted this cycle.
- ext_rvalid  out  1  external read data valid this cycle.
- ext_rdata  out  DW  external read data.
- mem_wr_en  out  1  DataMemory write enable.
- mem_addr  out  AW  DataMemory address.
- mem_wr_data  out  DW  DataMemory write data.
- mem_rd_data  in  DW  DataMemory read data, valid the cycle after the address is presented.

Behaviour:
- Grant rule (combinational, same cycle):
  - ext_gnt = ext_req & (!core_req | wait_cnt >= MAX_WAIT).
  - core_gnt (internal) = core_req & !ext_gnt.
  - core_stall = core_req & ext_gnt.
- Memory mux:
  - ext_gnt: mem_addr = ext_addr, mem_wr_data = ext_wdata, mem_wr_en = ext_we.
  - core_gnt: mem_addr = core_addr, mem_wr_data = core_wdata, mem_wr_en = core_we.
  - Neither granted: mem_wr_en = 0, mem_addr and mem_wr_data = 0.
- wait_cnt register, width clog2(MAX_WAIT+1):
  - ext_req & !ext_gnt: increment, saturating at MAX_WAIT.
  - ext_gnt or !ext_req: clear to 0.
- Read return (one-cycle latency):
  - Registered rd_owner_q is one of NONE/CORE/EXT; it records which granted access was a read (we = 0).
  - Next cycle, the matching rvalid = 1 and its rdata = mem_rd_data. Non-matching rdata = 0.
  - Writes never produce rvalid.
- Back-to-back:
  - A read grant in cycle N returns in N+1 even if the other requester is granted in N+1.
  - Both rvalids are never high together.
- Simultaneous requests: the core wins unless wait_cnt >= MAX_WAIT. Under continuous contention the external side gets one cycle in every MAX_WAIT+1.
- Core alone: core_stall is never asserted.
- ext_req deasserted before grant: the counter clears, with no side effects.
- Reset (reset = 0, asynchronous, including mid-access):
  - wait_cnt = 0, rd_owner_q = NONE.
  - All outputs 0: ext_gnt, core_stall, mem_wr_en, both rvalids, both rdatas, mem_addr, mem_wr_data.
  - A read in flight is dropped and no rvalid is produced.
  - Grants are also gated by reset so no write occurs while reset is low.
- Release: the first grant may occur in the first cycle after reset rises.

Test Plan:
- Reset mid-read: core read granted, reset pulled low before the return edge -> core_rvalid stays 0; all outputs 0 while reset = 0.
- Core only: core load to 0x10 with mem holding 0xDEADBEEF -> core_stall = 0; core_rvalid = 1 with core_rdata = 0xDEADBEEF one cycle later; ext_rvalid = 0.
- External only: ext write 0x20 <= 0x12345678, then ext read 0x20 -> ext_gnt = 1 each cycle; mem_wr_en = 1 on the first cycle only; ext_rvalid = 1 with ext_rdata = 0x12345678.
- Contention, MAX_WAIT = 4: core_req and ext_req held high for 10 cycles -> ext_gnt at cycles 4 and 9 only; core_stall exactly in those cycles; wait_cnt sequence 1,2,3,4,0,1,2,3,4,0.
- Interleaved reads: core read at cycle N, ext read at N+1 (forced) -> core_rvalid at N+1, ext_rvalid at N+2, each carrying its own address's data.
- Ext abort: ext_req high 2 cycles under core contention, then dropped -> ext_gnt never asserted, wait_cnt returns to 0, no memory write.
